// File: rtl/upstream_packetizer_if.sv
// Stream bundle between the sample source, the packetizer and gpif2_to_fifo32's RX port.
// master = packetizer side (consumes s_*, produces rx_*); slave = surrounding environment.
interface upstream_packetizer_if;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] rx_tdata;
  logic        rx_tlast;
  logic        rx_tvalid;
  logic        rx_tready;

  // Both streams: a word moves on a rising edge where tvalid && tready; a producer
  // never drops tvalid or changes tdata/tlast until that handshake has happened.
  modport master (
    input  s_tdata, s_tvalid, rx_tready,
    output s_tready, rx_tdata, rx_tlast, rx_tvalid
  );
  modport slave (
    output s_tdata, s_tvalid, rx_tready,
    input  s_tready, rx_tdata, rx_tlast, rx_tvalid
  );
endinterface

// File: rtl/upstream_packetizer.sv
// Frames an unframed 32-bit sample stream into header / payload / trailer packets with timeout padding.
// Optional: define PKT_CHECKSUM_EN to place a byte-XOR of accepted payload words in trailer[23:16].
module upstream_packetizer #(
  parameter int unsigned MAX_LEN  = 4096,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] PAD_WORD = 32'h0000_0000,
  parameter logic [7:0]  SYNC     = 8'hA5
) (
  input  logic                  gpif_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           cfg_len,
  upstream_packetizer_if.master bus,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [15:0]           seq_num,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, TRAILER} state_t;

  localparam int          SW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [15:0]   len, wcnt, vcnt;
  logic [SW-1:0] starve;
  logic          tflag;
  logic [7:0]    xsum;

  logic          loadable, out_hs;
  logic          load_en, load_last;
  logic [31:0]   load_data;
  logic          len_load, accept, pad_beat, starve_inc, tflag_set, done;
  logic [15:0]   len_clamped;

  assign loadable    = !bus.rx_tvalid || bus.rx_tready;
  assign out_hs      = bus.rx_tvalid && bus.rx_tready;
  assign len_clamped = (cfg_len == 16'd0) ? 16'd1 :
                       (cfg_len > MAX_LEN16) ? MAX_LEN16 : cfg_len;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_comb begin
    state_nxt    = state;
    bus.s_tready = 1'b0;
    load_en      = 1'b0;
    load_last    = 1'b0;
    load_data    = 32'h0;
    len_load     = 1'b0;
    accept       = 1'b0;
    pad_beat     = 1'b0;
    starve_inc   = 1'b0;
    tflag_set    = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (enable && bus.s_tvalid) begin
          len_load  = 1'b1;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        if (loadable) begin
          load_en   = 1'b1;
          load_data = {SYNC, 8'h00, seq_num};
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        bus.s_tready = loadable;
        if (loadable && bus.s_tvalid) begin
          accept    = 1'b1;
          load_en   = 1'b1;
          load_data = bus.s_tdata;
          if (wcnt + 16'd1 == len) state_nxt = TRAILER;
        end else if (loadable) begin
          starve_inc = 1'b1;
          if (starve + SW'(1) == TIMEOUT_C) begin
            tflag_set = 1'b1;
            state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (loadable) begin
          pad_beat  = 1'b1;
          load_en   = 1'b1;
          load_data = PAD_WORD;
          if (wcnt + 16'd1 == len) state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        // rx_tlast in the register means the trailer is already loaded and waiting.
        if (out_hs && bus.rx_tlast) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (loadable && !bus.rx_tlast) begin
          load_en   = 1'b1;
          load_last = 1'b1;
          load_data = {tflag, 7'b0, xsum, vcnt};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gpif_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.rx_tdata  <= 32'h0;
      bus.rx_tvalid <= 1'b0;
      bus.rx_tlast  <= 1'b0;
      pkt_done      <= 1'b0;
      seq_num       <= 16'h0;
      len           <= 16'h0;
      wcnt          <= 16'h0;
      vcnt          <= 16'h0;
      starve        <= '0;
      tflag         <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= done;
      if (load_en) begin
        bus.rx_tdata  <= load_data;
        bus.rx_tvalid <= 1'b1;
        bus.rx_tlast  <= load_last;
      end else if (loadable) begin
        bus.rx_tvalid <= 1'b0;
        bus.rx_tlast  <= 1'b0;
      end
      if (len_load) len <= len_clamped;
      if (accept) begin
        wcnt   <= wcnt + 16'd1;
        vcnt   <= vcnt + 16'd1;
        starve <= '0;
      end else if (starve_inc) begin
        starve <= starve + SW'(1);
      end
      if (pad_beat) wcnt <= wcnt + 16'd1;
      if (tflag_set) tflag <= 1'b1;
      if (done) begin
        seq_num <= seq_num + 16'd1;
        wcnt    <= 16'h0;
        vcnt    <= 16'h0;
        starve  <= '0;
        tflag   <= 1'b0;
      end
    end
  end

`ifdef PKT_CHECKSUM_EN
  always_ff @(posedge gpif_clk or negedge rst_n) begin
    if (!rst_n) begin
      xsum <= 8'h00;
    end else if (done) begin
      xsum <= 8'h00;
    end else if (accept) begin
      xsum <= xsum ^ bus.s_tdata[31:24] ^ bus.s_tdata[23:16]
                   ^ bus.s_tdata[15:8]  ^ bus.s_tdata[7:0];
    end
  end
`else
  assign xsum = 8'h00;
`endif

endmodule

// File: tb/tb_upstream_packetizer.sv
// Directed bench for upstream_packetizer: sample source driver, rx scoreboard, per-packet checks.
module tb_upstream_packetizer;

  logic        gpif_clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] cfg_len;
  logic        busy;
  logic        pkt_done;
  logic [15:0] seq_num;
  logic [2:0]  state_dbg;

  upstream_packetizer_if bus ();

  upstream_packetizer #(
    .MAX_LEN (4096),
    .TIMEOUT (16),
    .PAD_WORD(32'hCAFE_0000),
    .SYNC    (8'hA5)
  ) dut (
    .gpif_clk (gpif_clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cfg_len  (cfg_len),
    .bus      (bus),
    .busy     (busy),
    .pkt_done (pkt_done),
    .seq_num  (seq_num),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    gpif_clk = 1'b0;
    forever #5 gpif_clk = ~gpif_clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] src_q[$];
  int          beat_cyc_q[$];
  int          cyc = 0;
  int          beat_cnt = 0;
  int          pkt_cnt = 0;
  int          exp_pkt = 0;
  logic        rdy_toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_word(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic src_word(input logic [31:0] d);
    src_q.push_back(d);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge gpif_clk);
      n++;
    end
    check(tag, 64'(n < max_cyc), 64'd1);
    repeat (2) @(negedge gpif_clk);
  endtask

  task automatic wait_beats(input int target, input int max_cyc);
    int n;
    n = 0;
    while (beat_cnt < target && n < max_cyc) begin
      @(negedge gpif_clk);
      n++;
    end
    check("wait_beats", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic end_packet(input string tag, input logic [15:0] exp_seq);
    exp_pkt++;
    check({tag, "_seq"}, 64'(seq_num), 64'(exp_seq));
    check({tag, "_pkts"}, 64'(pkt_cnt), 64'(exp_pkt));
    check({tag, "_idle"}, 64'(state_dbg), 64'd0);
  endtask

  // driver: sample source from src_q, rx_tready pattern
  initial begin : driver
    logic take;
    bus.s_tvalid  = 1'b0;
    bus.s_tdata   = 32'h0;
    bus.rx_tready = 1'b1;
    forever begin
      @(negedge gpif_clk);
      take = bus.s_tvalid && bus.s_tready;
      @(posedge gpif_clk);
      #1;
      if (take && src_q.size() > 0) src_q.delete(0);
      if (src_q.size() > 0) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = src_q[0];
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 32'h0;
      end
      bus.rx_tready = rdy_toggle ? ~bus.rx_tready : 1'b1;
    end
  end

  // scoreboard: rx beats against exp_q, hold stability while stalled, pkt_done pulses
  initial begin : monitor
    logic        prev_stall;
    logic [32:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge gpif_clk);
      cyc++;
      if (prev_stall)
        check("hold", 64'({bus.rx_tvalid, bus.rx_tlast, bus.rx_tdata}), 64'({1'b1, prev_word}));
      prev_stall = bus.rx_tvalid && !bus.rx_tready;
      prev_word  = {bus.rx_tlast, bus.rx_tdata};
      if (pkt_done) pkt_cnt++;
      if (bus.rx_tvalid && bus.rx_tready) begin
        beat_cnt++;
        beat_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) check("rx_word", 64'({bus.rx_tlast, bus.rx_tdata}), 64'(exp_q.pop_front()));
        else check("rx_extra", 64'(exp_q.size()), 64'd1);
      end
    end
  end

  initial begin : main
    rst_n   = 1'b0;
    enable  = 1'b0;
    cfg_len = 16'd0;
    repeat (3) @(posedge gpif_clk);
    #3;
    check("rst_tvalid", 64'(bus.rx_tvalid), 64'd0);
    check("rst_tlast",  64'(bus.rx_tlast),  64'd0);
    check("rst_tdata",  64'(bus.rx_tdata),  64'd0);
    check("rst_sready", 64'(bus.s_tready),  64'd0);
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_done",   64'(pkt_done),      64'd0);
    check("rst_seq",    64'(seq_num),       64'd0);
    check("rst_state",  64'(state_dbg),     64'd0);
    @(negedge gpif_clk);
    rst_n = 1'b1;

    // 1: len 4, continuous samples, rx always ready
    @(negedge gpif_clk);
    beat_cyc_q.delete();
    cfg_len = 16'd4;
    enable  = 1'b1;
    exp_word(1'b0, 32'hA500_0000);
    for (int i = 1; i <= 4; i++) begin
      src_word(32'(i));
      exp_word(1'b0, 32'(i));
    end
    exp_word(1'b1, 32'h0000_0004);
    wait_drain("t1_drain", 200);
    end_packet("t1", 16'd1);
    check("t1_beats", 64'(beat_cyc_q.size()), 64'd6);
    if (beat_cyc_q.size() == 6)
      check("t1_b2b", 64'(beat_cyc_q[5] - beat_cyc_q[0]), 64'd5);

    // 2: same shape with rx_tready toggling; cfg_len change mid-packet is ignored
    rdy_toggle = 1'b1;
    exp_word(1'b0, 32'hA500_0001);
    for (int i = 5; i <= 8; i++) begin
      src_word(32'(i));
      exp_word(1'b0, 32'(i));
    end
    exp_word(1'b1, 32'h0000_0004);
    @(negedge gpif_clk);
    while (!busy) @(negedge gpif_clk);
    cfg_len = 16'd2;
    wait_drain("t2_drain", 200);
    end_packet("t2", 16'd2);
    rdy_toggle = 1'b0;

    // 3: len 8, three samples then starvation -> 5 pads after 16 starved cycles
    cfg_len = 16'd8;
    beat_cyc_q.delete();
    exp_word(1'b0, 32'hA500_0002);
    src_word(32'h11); exp_word(1'b0, 32'h11);
    src_word(32'h22); exp_word(1'b0, 32'h22);
    src_word(32'h33); exp_word(1'b0, 32'h33);
    for (int i = 0; i < 5; i++) exp_word(1'b0, 32'hCAFE_0000);
    exp_word(1'b1, 32'h8000_0003);
    @(negedge gpif_clk);
    while (!busy) @(negedge gpif_clk);
    enable = 1'b0;
    wait_drain("t3_drain", 300);
    end_packet("t3", 16'd3);
    if (beat_cyc_q.size() == 10)
      check("t3_timeout_gap", 64'(beat_cyc_q[4] - beat_cyc_q[3]), 64'd17);
    else
      check("t3_beats", 64'(beat_cyc_q.size()), 64'd10);

    // 4: enable low holds off a new packet; then cfg_len=0 clamps to 1
    cfg_len = 16'd0;
    src_word(32'h0000_00AB);
    repeat (8) @(negedge gpif_clk);
    check("t4_enable_gate", 64'(busy), 64'd0);
    exp_word(1'b0, 32'hA500_0003);
    exp_word(1'b0, 32'h0000_00AB);
    exp_word(1'b1, 32'h0000_0001);
    enable = 1'b1;
    wait_drain("t4_drain", 200);
    end_packet("t4", 16'd4);

    // 5: cfg_len=65535 clamps to MAX_LEN=4096
    cfg_len = 16'hFFFF;
    exp_word(1'b0, 32'hA500_0004);
    for (int i = 0; i < 4096; i++) begin
      src_word(32'h1000_0000 + 32'(i));
      exp_word(1'b0, 32'h1000_0000 + 32'(i));
    end
    exp_word(1'b1, 32'h0000_1000);
    wait_drain("t5_drain", 6000);
    end_packet("t5", 16'd5);

    // 6: reset mid-payload abandons the packet and clears seq_num
    cfg_len = 16'd8;
    exp_word(1'b0, 32'hA500_0005);
    for (int i = 0; i < 8; i++) begin
      src_word(32'h2000_0000 + 32'(i));
      exp_word(1'b0, 32'h2000_0000 + 32'(i));
    end
    wait_beats(beat_cnt + 3, 200);
    @(posedge gpif_clk);
    #2;
    check("t6_pre_valid", 64'(bus.rx_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.rx_tvalid), 64'd0);
    check("t6_rst_seq",   64'(seq_num),       64'd0);
    check("t6_rst_busy",  64'(busy),          64'd0);
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge gpif_clk);
    rst_n   = 1'b1;
    cfg_len = 16'd1;
    exp_pkt = pkt_cnt;
    exp_word(1'b0, 32'hA500_0000);
    src_word(32'h0000_0077);
    exp_word(1'b0, 32'h0000_0077);
    exp_word(1'b1, 32'h0000_0001);
    wait_drain("t6_drain", 200);
    end_packet("t6", 16'd1);

    // 7: trailer checksum byte (0x44 when the checksum build is used)
    cfg_len = 16'd2;
    exp_word(1'b0, 32'hA500_0001);
    src_word(32'h0102_0304); exp_word(1'b0, 32'h0102_0304);
    src_word(32'h1020_3040); exp_word(1'b0, 32'h1020_3040);
`ifdef PKT_CHECKSUM_EN
    exp_word(1'b1, 32'h0044_0002);
`else
    exp_word(1'b1, 32'h0000_0002);
`endif
    wait_drain("t7_drain", 200);
    end_packet("t7", 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
